// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encodings, widths and defaults.
// The receiver and the transmitter use the same state encoding style.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int CNT_W            = 8;
    localparam int IDX_W            = 3;
    localparam int CLKS_PER_BIT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } uart_state_e;

    // Count at which the start bit is re-checked (its middle).
    function automatic logic [CNT_W-1:0] half_bit_cnt(input int cpb);
        return CNT_W'((cpb - 1) / 2);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Synchroniser flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= RST_VAL;
            ff2_q <= RST_VAL;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/read handshake toward the consumer,
// framing-error pulse and sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rx,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              RX_Done,
    output logic              RX_Valid,
    output logic              Frame_Err,
    output logic              Overrun
);

    localparam logic [CNT_W-1:0] HALF_CNT = half_bit_cnt(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic              rx_s;
    logic              byte_ok_s;

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              done_q,  done_d;
    logic              valid_q, valid_d;
    logic              ferr_q,  ferr_d;
    logic              ovr_q,   ovr_d;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (Rx),
        .q_o    (rx_s)
    );

    // State, counters, data and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Receive FSM: next state, bit timing and shift register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        byte_ok_s = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q < HALF_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (!rx_s) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    // Line went back high before mid-start: treat as a glitch.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        data_d    = shift_q;
                        byte_ok_s = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BRK;
                    end
                end
            end
            ST_BRK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BRK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Consumer handshake: a read in the completion cycle consumes the old byte, so no overrun.
    always_comb begin
        done_d  = byte_ok_s;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (byte_ok_s) begin
            valid_d = 1'b1;
            if (valid_q && !rd_en) begin
                ovr_d = 1'b1;
            end else if (valid_q && rd_en) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (rd_en && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            ovr_d   = ovr_q;
        end
    end

    assign out_data  = data_q;
    assign RX_Done   = done_q;
    assign RX_Valid  = valid_q;
    assign Frame_Err = ferr_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=4): table-driven frames plus hand-written
// corner sequences; received bytes and their completion cycle are checked against a scoreboard.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rx;
    logic       rd_en;
    logic [7:0] out_data;
    logic       RX_Done;
    logic       RX_Valid;
    logic       Frame_Err;
    logic       Overrun;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    bit ovr_seen = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       do_rd;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;
    vec_t tbl[5];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (Rx),
        .rd_en     (rd_en),
        .out_data  (out_data),
        .RX_Done   (RX_Done),
        .RX_Valid  (RX_Valid),
        .Frame_Err (Frame_Err),
        .Overrun   (Overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completion monitor: every RX_Done must match the oldest expected byte and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (Overrun) ovr_seen = 1'b1;
        if (Frame_Err) ferr_cnt++;
        if (RX_Done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got data=%0h want no completion (cycle %0d)",
                         out_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("rx_data", 32'(out_data), 32'(e.data));
                chk("rx_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the start bit is captured on the next edge (e0).
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_done);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1 + 40;
        if (expect_done) sb.push_back(e);
        Rx = 1'b0;
        wait_cycles(CPB);
        for (int b = 0; b < 8; b++) begin
            Rx = d[b];
            wait_cycles(CPB);
        end
        Rx = stop;
        wait_cycles(CPB);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        wait_cycles(1);
        rd_en = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        int f0;
        int d0;
        int t;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1};
        tbl[4] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 0};

        rst   = 1'b0;
        Rx    = 1'b1;
        rd_en = 1'b0;
        wait_cycles(3);
        chk("reset_out_data", 32'(out_data), 32'h0);
        chk("reset_flags", 32'({RX_Done, RX_Valid, Frame_Err, Overrun}), 32'h0);
        rst = 1'b1;

        // Idle line high for 100 cycles.
        wait_cycles(100);
        chk("idle_out_data", 32'(out_data), 32'h0);
        chk("idle_flags", 32'({RX_Done, RX_Valid, Frame_Err, Overrun}), 32'h0);
        chk("idle_done_cnt", 32'(done_cnt), 32'h0);
        chk("idle_ferr_cnt", 32'(ferr_cnt), 32'h0);

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].stop);
            Rx = 1'b1;
            wait_cycles(8);
            chk($sformatf("row%0d_out", i), 32'(out_data), 32'(tbl[i].exp_out));
            chk($sformatf("row%0d_valid", i), 32'(RX_Valid), 32'(tbl[i].exp_valid));
            chk($sformatf("row%0d_ovr", i), 32'(Overrun), 32'(tbl[i].exp_ovr));
            chk($sformatf("row%0d_ferr", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
            if (tbl[i].do_rd) begin
                read_pulse();
                chk($sformatf("row%0d_valid_rd", i), 32'(RX_Valid), 32'h0);
                chk($sformatf("row%0d_ovr_rd", i), 32'(Overrun), 32'h0);
            end
        end

        // Back-to-back frames, read during the first completion cycle.
        ovr_seen = 1'b0;
        t = cyc + 1 + 40;
        fork
            begin
                send_frame(8'h3C, 1'b1, 1'b1);
                send_frame(8'hC3, 1'b1, 1'b1);
            end
            begin
                while (cyc < t) begin
                    @(posedge clk);
                    #1;
                end
                rd_en = 1'b1;
                wait_cycles(1);
                rd_en = 1'b0;
            end
        join
        wait_cycles(8);
        chk("b2b_rd_out", 32'(out_data), 32'hC3);
        chk("b2b_rd_ovr_seen", 32'(ovr_seen), 32'h0);
        chk("b2b_rd_valid", 32'(RX_Valid), 32'h1);
        read_pulse();

        // Back-to-back frames without reading: overrun.
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_cycles(8);
        chk("b2b_ovr", 32'(Overrun), 32'h1);
        chk("b2b_ovr_out", 32'(out_data), 32'hC3);
        read_pulse();
        chk("b2b_ovr_clr", 32'(Overrun), 32'h0);
        chk("b2b_valid_clr", 32'(RX_Valid), 32'h0);

        // Framing error followed by a held-low break.
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        wait_cycles(50);
        Rx = 1'b1;
        wait_cycles(8);
        chk("brk_ferr_once", 32'(ferr_cnt - f0), 32'h1);
        chk("brk_out_kept", 32'(out_data), 32'hC3);
        chk("brk_valid_kept", 32'(RX_Valid), 32'h0);
        send_frame(8'h0F, 1'b1, 1'b1);
        wait_cycles(8);
        chk("after_brk_out", 32'(out_data), 32'h0F);
        chk("after_brk_valid", 32'(RX_Valid), 32'h1);

        // One-cycle glitch must be ignored.
        f0 = ferr_cnt;
        d0 = done_cnt;
        Rx = 1'b0;
        wait_cycles(1);
        Rx = 1'b1;
        wait_cycles(60);
        chk("glitch_done", 32'(done_cnt - d0), 32'h0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
        chk("glitch_out", 32'(out_data), 32'h0F);
        chk("glitch_valid", 32'(RX_Valid), 32'h1);

        // Reset in the middle of a data phase.
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                wait_cycles(16);
                rst = 1'b0;
                #1;
                chk("midrst_out", 32'(out_data), 32'h0);
                chk("midrst_flags", 32'({RX_Done, RX_Valid, Frame_Err, Overrun}), 32'h0);
            end
        join
        rst = 1'b1;
        wait_cycles(5);
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cycles(8);
        chk("post_rst_out", 32'(out_data), 32'h81);
        chk("post_rst_valid", 32'(RX_Valid), 32'h1);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the downstream partner of the UART transmitter.
- Samples the asynchronous serial line `Rx` (8N1, LSB first, idle high, `CLKS_PER_BIT` clocks per bit).
- Presents each received byte on `out_data`, flagged by `RX_Done`, with a valid/read handshake toward the consuming logic.
- Reports framing errors and overruns.

Parameters:
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; legal range 2..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Rx`  in  1  serial input line; asynchronous to `clk`.
- `rd_en`  in  1  consumer acknowledge; clears `RX_Valid`.
- `out_data`  out  8  last correctly framed byte.
- `RX_Done`  out  1  one-cycle pulse when a new byte is loaded into `out_data`.
- `RX_Valid`  out  1  byte pending; set with `RX_Done`, cleared by `rd_en`.
- `Frame_Err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `Overrun`  out  1  sticky; a byte arrived while `RX_Valid` was still set.

Behaviour:

Reset (`rst`=0, asynchronous):
- State IDLE; both synchroniser flops = 1; counters = 0.
- `out_data` = 0; `RX_Done`, `RX_Valid`, `Frame_Err`, `Overrun` = 0.
- Reset mid-frame abandons the frame. No outputs pulse.

Synchroniser and counters:
- `Rx` passes through 2 flops to give `rx_s`. All decisions use `rx_s` only.
- `H` = (`CLKS_PER_BIT`-1)/2 (integer division).
- Bit counter is 8 bits wide. Bit index is 3 bits.

States:
- IDLE:
  - Counter = 0.
  - `rx_s`=0 -> START.
- START:
  - While count < `H`: count++.
  - At count == `H`, if `rx_s`=0: count=0, bit index=0 -> DATA.
  - At count == `H`, if `rx_s`=1: false start (glitch) -> IDLE, no outputs.
- DATA:
  - While count < `CLKS_PER_BIT`-1: count++.
  - At count == `CLKS_PER_BIT`-1: shift[bit index] <= `rx_s`; count=0.
  - After bit index 7 -> STOP; otherwise bit index++.
  - This samples at mid-bit.
- STOP:
  - Same counting as DATA; sample at count == `CLKS_PER_BIT`-1.
  - If `rx_s`=1: `out_data` <= shift; `RX_Done` pulse; `RX_Valid` <= 1 -> IDLE (returns at mid-stop, so it can catch a back-to-back start).
  - If `rx_s`=0: `Frame_Err` pulse; `out_data`/`RX_Valid` unchanged -> BRK.
- BRK:
  - Wait for `rx_s`=1 -> IDLE.
  - A held-low line (break) yields exactly one `Frame_Err`.
- Illegal state -> IDLE.

Latency:
- Let e0 be the first `clk` edge at which `Rx`=0 is captured.
- `RX_Done` is high in the cycle after edge e0 + 3 + `H` + 9*`CLKS_PER_BIT`.
- For `CLKS_PER_BIT`=4 that is e0+40.

Handshake:
- `rd_en` with `RX_Valid`=1 clears `RX_Valid` next cycle and clears `Overrun`.
- `rd_en` with `RX_Valid`=0: no effect.
- Byte completes while `RX_Valid`=1 and `rd_en`=0: `out_data` overwritten, `RX_Done` pulses, `Overrun` <= 1.
- `rd_en` and byte completion in the same cycle: `RX_Valid` stays 1, new data is loaded, `Overrun` = 0 (the read wins for the old byte).

Decomposition:
- Shared package `uart_pkg`:
  - State encodings IDLE/START/DATA/STOP/BRK as 3-bit constants, shared with the transmitter encoding style.
  - Data width 8.
  - Default `CLKS_PER_BIT`.
- One natural sub-module, `uart_sync2`: the 2-flop synchroniser with reset value parameterised (1 here).
- The FSM, counters and handshake stay in `uart_rx`.

Test Plan:
All scenarios use `CLKS_PER_BIT`=4.
1. Reset then idle line high for 100 cycles -> all outputs 0, `out_data`=0x00.
2. Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1, 4 clk per bit) -> `RX_Done` single pulse at e0+40, `out_data`=0xA5, `RX_Valid`=1. Then `rd_en` one cycle -> `RX_Valid`=0.
3. Back-to-back frames 0x3C then 0xC3 with no idle gap; `rd_en` asserted in the cycle `RX_Done` is high for the first -> two `RX_Done` pulses, final `out_data`=0xC3, `Overrun` never set.
4. Same two frames with no `rd_en` -> `Overrun`=1 after the second, `out_data`=0xC3. Then `rd_en` -> `Overrun`=0, `RX_Valid`=0.
5. Frame 0x55 with stop bit 0, then line held low 50 cycles, then high -> exactly one `Frame_Err` pulse, `out_data` keeps its prior value, `RX_Valid` unchanged. Next valid frame 0x0F is received correctly.
6. 1-cycle low glitch on `Rx` -> no output activity. Separately, assert `rst` mid-DATA of frame 0xFF -> outputs 0 immediately; next clean frame 0x81 is received correctly.
